uart_rx_monitor: RTL and testbench
==================================

// Module: uart_rx_monitor
// PURPOSE
//  Parametrised, synthesizable UART receiver for the Microwatt SoC. It decodes frames on a serial rx pin
//  with configurable data bits, parity and stop bits, and buffers them in a small FIFO behind a valid/ready port.
//  It can compare every received byte against a programmed expected value and flag the result.
//  It replaces fixed bench-only receivers: usable on-chip as a debug monitor of the UART tx line, and in DV.
// PARAMETERS
//  CLK_FREQ    100000000  system clock frequency, Hz
//  BAUD        115200     line rate, bit/s
//  OVERSAMPLE  16         ticks per bit, even, >=8
//  DATA_BITS   8          data bits per frame, 5..9
//  PARITY      0          0=none, 1=even, 2=odd
//  STOP_BITS   1          1 or 2
//  FIFO_DEPTH  4          entries, power of 2, >=2
// PORTS
//  clock          in   1          system clock
//  resetb         in   1          asynchronous active-low reset
//  rx             in   1          serial input, asynchronous to clock, idle high
//  cfg_expect_en  in   1          enable expected-byte compare
//  cfg_expect     in   DATA_BITS  expected byte
//  clear_status   in   1          synchronous clear of the sticky overflow flag
//  rd_valid       out  1          FIFO not empty
//  rd_ready       in   1          consumer accepts the head entry
//  rd_data        out  DATA_BITS  head entry data
//  rd_frame_err   out  1          head entry: a stop bit was sampled low
//  rd_parity_err  out  1          head entry: parity mismatch (always 0 when PARITY=0)
//  match          out  1          1-cycle pulse: pushed byte equals cfg_expect with no errors
//  mismatch       out  1          1-cycle pulse: pushed byte differs, or has an error
//  overflow       out  1          sticky: a frame was dropped because the FIFO was full
//  busy           out  1          receiver not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty. State IDLE. rx synchroniser flops = 1.
//  rx passes through a 2-flop synchroniser. Tick divider DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated.
//  Divider and tick counter restart on start-bit detection.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: a synchronised 1->0 edge moves to START.
//   START: at tick OVERSAMPLE/2 the line is re-checked. If low -> DATA. If high -> IDLE (glitch rejected, no push).
//   DATA: each bit is the majority of 3 samples at ticks H-1, H and H+1, where H=OVERSAMPLE/2. LSB first.
//    After DATA_BITS bits -> PARITY when PARITY!=0, else -> STOP.
//   PARITY: majority-sampled. Error when (XOR of data ^ bit) != (PARITY==2).
//   STOP: STOP_BITS bits, each majority-sampled. Any low sample sets frame_err.
//    After the mid-point of the last stop bit -> IDLE. The next start edge can then be caught within the same stop period.
//  Push: one cycle after the last stop sample, {parity_err, frame_err, data} is written.
//   rd_valid rises on the following cycle. Frames with errors are still pushed, with flags set.
//  FIFO: first-word-fall-through. Pop when rd_valid && rd_ready.
//   Push when full and no pop in the same cycle: the frame is dropped and overflow is set.
//   Push when full with a pop in the same cycle: the frame is accepted.
//   Push and pop when empty is not possible, because of the one-cycle valid latency.
//  Compare: evaluated on a successful push. match and mismatch stay 0 when cfg_expect_en=0.
//   Dropped frames generate no pulse.
//  overflow: cleared only by reset or clear_status. If clear_status and a new overflow occur in the same cycle, overflow stays 1.
//  resetb asserted mid-frame: the partial frame is discarded. After release, the FSM waits for a fresh 1->0 edge.
//  A line held low (break) yields one frame: data=0 and frame_err=1. No further frames until rx has returned high.
// TESTING  (defaults, 100 MHz clock, bit time 8680 ns, DIV=54)
//  1. 8N1: send 0x37, cfg_expect=0x37, en=1 -> rd_data=0x37, no error flags, one match pulse, busy low after the stop bit.
//  2. rx low for 2000 ns, then high -> no push, rd_valid stays 0, FSM returns to IDLE.
//  3. PARITY=1: send 0x37 with parity bit 0 -> rd_parity_err=1, mismatch pulse. Then the correct parity bit 1 -> no error, match.
//  4. Stop bit driven low on 0xA5 -> rd_data=0xA5, rd_frame_err=1, mismatch pulse.
//  5. rd_ready=0, send 0x01..0x05 back-to-back -> 4 entries 0x01..0x04, overflow=1. Drain with rd_ready=1 -> 0x01..0x04 in order.
//     Then clear_status -> overflow=0.
//  6. resetb pulsed low during data bit 3 -> outputs zero, FIFO empty. Then send 0x55 -> rd_data=0x55, no errors.

Source files
------------

// File: rtl/uart_rx_monitor.sv
// UART receiver with majority-vote bit sampling, a first-word-fall-through result FIFO
// and an optional expected-byte comparator, usable as an on-chip line monitor.
module uart_rx_monitor #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 rx,
    input  logic                 cfg_expect_en,
    input  logic [DATA_BITS-1:0] cfg_expect,
    input  logic                 clear_status,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_frame_err,
    output logic                 rd_parity_err,
    output logic                 match,
    output logic                 mismatch,
    output logic                 overflow,
    output logic                 busy
);

    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int EW     = DATA_BITS + 2;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] T_S0      = TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [TICK_W-1:0] T_S1      = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] T_S2      = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] T_LAST    = TICK_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS == 2);
    localparam logic              ODD_PAR   = 1'(PARITY == 2);
    localparam logic [AW:0]       CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e state_q, state_d;

    // ---------------- rx synchroniser and start-edge detection ----------------
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0] flush_q;
    logic       armed_q;
    logic       start_edge;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            flush_q   <= 2'd0;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
            // Edges are trusted only once the chain holds real line values and has seen high.
            armed_q   <= armed_q | ((flush_q == 2'd3) & rx_prev_q & rx_sync_q);
        end
    end

    assign start_edge = armed_q & rx_prev_q & ~rx_sync_q;

    // ---------------- baud tick generator ----------------
    logic [DIV_W-1:0]  div_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic              tick_s0, tick_s1, tick_s2, tick_end;

    assign tick     = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign tick_s0  = tick && (tick_cnt_q == T_S0);
    assign tick_s1  = tick && (tick_cnt_q == T_S1);
    assign tick_s2  = tick && (tick_cnt_q == T_S2);
    assign tick_end = tick && (tick_cnt_q == T_LAST);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            div_q      <= '0;
            tick_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            div_q      <= '0;
            tick_cnt_q <= '0;
        end else if (tick) begin
            div_q      <= '0;
            tick_cnt_q <= tick_end ? '0 : tick_cnt_q + 1'b1;
        end else begin
            div_q      <= div_q + 1'b1;
        end
    end

    // ---------------- receive FSM ----------------
    logic [3:0] bit_cnt_q;
    logic       stop_cnt_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: assigning a default first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_edge) state_d = S_START;
            S_START: begin
                if (tick_s1 && rx_sync_q) state_d = S_IDLE;
                else if (tick_end)        state_d = S_DATA;
            end
            S_DATA:   if (tick_end && bit_cnt_q == BIT_LAST)
                          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tick_end) state_d = S_STOP;
            S_STOP:   if (tick_s2 && stop_cnt_q == STOP_LAST) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    logic data_done, par_done, stop_sample, stop_done;

    always_comb begin
        busy        = (state_q != S_IDLE);
        data_done   = (state_q == S_DATA)   && tick_s2;
        par_done    = (state_q == S_PARITY) && tick_s2;
        stop_sample = (state_q == S_STOP)   && (tick_s0 || tick_s1 || tick_s2);
        stop_done   = (state_q == S_STOP)   && tick_s2 && (stop_cnt_q == STOP_LAST);
    end

    // ---------------- bit datapath ----------------
    logic                 samp0_q, samp1_q, maj;
    logic [DATA_BITS-1:0] data_q;
    logic                 frame_err_q, parity_err_q, push_q;

    assign maj = (samp0_q & samp1_q) | (samp0_q & rx_sync_q) | (samp1_q & rx_sync_q);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            samp0_q      <= 1'b0;
            samp1_q      <= 1'b0;
            data_q       <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            push_q       <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start_edge) begin
                bit_cnt_q    <= '0;
                stop_cnt_q   <= 1'b0;
                frame_err_q  <= 1'b0;
                parity_err_q <= 1'b0;
            end
            if (tick_s0) samp0_q <= rx_sync_q;
            if (tick_s1) samp1_q <= rx_sync_q;
            if (data_done) data_q <= {maj, data_q[DATA_BITS-1:1]};
            if (state_q == S_DATA && tick_end) bit_cnt_q <= bit_cnt_q + 4'd1;
            if (par_done) parity_err_q <= ((^data_q) ^ maj) != ODD_PAR;
            if (stop_sample && !rx_sync_q) frame_err_q <= 1'b1;
            if (state_q == S_STOP && tick_end) stop_cnt_q <= 1'b1;
            push_q <= stop_done;
        end
    end

    // ---------------- result FIFO ----------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [EW-1:0] wr_entry, head;
    logic          pop, full, accept, drop, good;

    assign wr_entry = {parity_err_q, frame_err_q, data_q};
    assign full     = (count_q == CNT_FULL);
    assign pop      = rd_valid && rd_ready;
    assign accept   = push_q && (!full || pop);
    assign drop     = push_q && full && !pop;
    assign good     = !parity_err_q && !frame_err_q && (data_q == cfg_expect);

    // NOTE: storage is not reset; outputs are masked by rd_valid so stale entries never leak.
    always_ff @(posedge clock) begin
        if (accept) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign rd_valid      = (count_q != '0);
    assign rd_data       = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_frame_err  = rd_valid & head[DATA_BITS];
    assign rd_parity_err = rd_valid & head[DATA_BITS+1];

    // ---------------- compare pulses and sticky overflow ----------------
    logic match_q, mismatch_q, overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (clear_status) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            match_q    <= accept && cfg_expect_en && good;
            mismatch_q <= accept && cfg_expect_en && !good;
            overflow_q <= overflow_d;
        end
    end

    assign match    = match_q;
    assign mismatch = mismatch_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench: an 8N1 receiver and an 8E1 receiver share clock, reset and config;
// each frame's expected byte, flags and pulse counts are written out by hand.
module tb_uart_rx_monitor;

    localparam int BIT = 640;  // 100 MHz, BAUD 1562500, x16 -> DIV=4, 64 cycles/bit

    logic       clock = 1'b0;
    logic       resetb, rx_a, rx_b, cfg_expect_en, clear_status, rd_ready;
    logic [7:0] cfg_expect;

    logic       a_valid, a_fe, a_pe, a_match, a_mismatch, a_ovf, a_busy;
    logic [7:0] a_data;
    logic       b_valid, b_fe, b_pe, b_match, b_mismatch, b_ovf, b_busy;
    logic [7:0] b_data;

    int n_tests = 0, n_fail = 0;
    int a_match_n = 0, a_mm_n = 0, b_match_n = 0, b_mm_n = 0;
    int m0, mm0;

    always #5 clock = ~clock;

    uart_rx_monitor #(
        .CLK_FREQ(100000000), .BAUD(1562500), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_a (
        .clock(clock), .resetb(resetb), .rx(rx_a),
        .cfg_expect_en(cfg_expect_en), .cfg_expect(cfg_expect), .clear_status(clear_status),
        .rd_valid(a_valid), .rd_ready(rd_ready), .rd_data(a_data),
        .rd_frame_err(a_fe), .rd_parity_err(a_pe), .match(a_match), .mismatch(a_mismatch),
        .overflow(a_ovf), .busy(a_busy)
    );

    uart_rx_monitor #(
        .CLK_FREQ(100000000), .BAUD(1562500), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_b (
        .clock(clock), .resetb(resetb), .rx(rx_b),
        .cfg_expect_en(cfg_expect_en), .cfg_expect(cfg_expect), .clear_status(clear_status),
        .rd_valid(b_valid), .rd_ready(rd_ready), .rd_data(b_data),
        .rd_frame_err(b_fe), .rd_parity_err(b_pe), .match(b_match), .mismatch(b_mismatch),
        .overflow(b_ovf), .busy(b_busy)
    );

    always @(posedge clock) begin
        if (a_match)    a_match_n <= a_match_n + 1;
        if (a_mismatch) a_mm_n    <= a_mm_n + 1;
        if (b_match)    b_match_n <= b_match_n + 1;
        if (b_mismatch) b_mm_n    <= b_mm_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop_bit);
        rx_a = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            #BIT;
        end
        rx_a = stop_bit;
        #BIT;
        rx_a = 1'b1;
    endtask

    task automatic send_b(input logic [7:0] d, input logic par_bit);
        rx_b = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx_b = d[i];
            #BIT;
        end
        rx_b = par_bit;
        #BIT;
        rx_b = 1'b1;
        #BIT;
    endtask

    task automatic pop_one();
        @(negedge clock);
        rd_ready = 1'b1;
        @(negedge clock);
        rd_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        cfg_expect_en = 1'b0; cfg_expect = 8'h00; clear_status = 1'b0; rd_ready = 1'b0;
        #100;
        @(negedge clock);
        check("reset_outputs_a", {a_valid, a_data, a_fe, a_pe, a_match, a_mismatch, a_ovf, a_busy}, 32'h0);
        check("reset_outputs_b", {b_valid, b_data, b_fe, b_pe, b_match, b_mismatch, b_ovf, b_busy}, 32'h0);
        resetb = 1'b1;
        #200;

        // 8N1 frame with a matching expected byte
        cfg_expect = 8'h37; cfg_expect_en = 1'b1;
        m0 = a_match_n; mm0 = a_mm_n;
        @(negedge clock);
        send_a(8'h37, 1'b1);
        @(negedge clock);
        check("t1_valid", a_valid, 1);
        check("t1_data", a_data, 8'h37);
        check("t1_flags", {a_fe, a_pe}, 0);
        check("t1_match_pulses", a_match_n - m0, 1);
        check("t1_mismatch_pulses", a_mm_n - mm0, 0);
        check("t1_busy_after_stop", a_busy, 0);
        pop_one();
        check("t1_empty_after_pop", a_valid, 0);

        // parity receiver: wrong even-parity bit, then the correct one
        m0 = b_match_n; mm0 = b_mm_n;
        send_b(8'h37, 1'b0);
        @(negedge clock);
        check("t3_bad_valid", b_valid, 1);
        check("t3_bad_data", b_data, 8'h37);
        check("t3_bad_parity_flag", b_pe, 1);
        check("t3_bad_frame_flag", b_fe, 0);
        check("t3_bad_mismatch_pulses", b_mm_n - mm0, 1);
        pop_one();
        send_b(8'h37, 1'b1);
        @(negedge clock);
        check("t3_good_data", b_data, 8'h37);
        check("t3_good_parity_flag", b_pe, 0);
        check("t3_good_match_pulses", b_match_n - m0, 1);
        pop_one();
        check("t3_empty", b_valid, 0);

        // start glitch shorter than half a bit
        rx_a = 1'b0;
        #100;
        check("t2_busy_in_start", a_busy, 1);
        #100;
        rx_a = 1'b1;
        #BIT;
        @(negedge clock);
        check("t2_no_push", a_valid, 0);
        check("t2_idle", a_busy, 0);

        // stop bit sampled low
        m0 = a_match_n; mm0 = a_mm_n;
        send_a(8'hA5, 1'b0);
        #BIT;
        @(negedge clock);
        check("t4_data", a_data, 8'hA5);
        check("t4_frame_err", a_fe, 1);
        check("t4_parity_err", a_pe, 0);
        check("t4_mismatch_pulses", a_mm_n - mm0, 1);
        pop_one();

        // break: one all-zero frame with frame error, nothing more while low
        rx_a = 1'b0;
        #(15 * BIT);
        @(negedge clock);
        check("brk_valid", a_valid, 1);
        check("brk_entry", {a_fe, a_data}, 9'h100);
        pop_one();
        #(5 * BIT);
        check("brk_single_frame", a_valid, 0);
        check("brk_idle", a_busy, 0);
        rx_a = 1'b1;
        #(2 * BIT);

        // FIFO overflow: 5 frames into a 4-deep FIFO, the dropped one makes no pulse
        cfg_expect = 8'h05;
        m0 = a_match_n; mm0 = a_mm_n;
        @(negedge clock);
        for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b1);
        @(negedge clock);
        check("t5_overflow", a_ovf, 1);
        check("t5_match_pulses", a_match_n - m0, 0);
        check("t5_mismatch_pulses", a_mm_n - mm0, 4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t5_drain_valid_%0d", i), a_valid, 1);
            check($sformatf("t5_drain_data_%0d", i), a_data, i);
            pop_one();
        end
        check("t5_drained", a_valid, 0);
        check("t5_overflow_sticky", a_ovf, 1);
        @(negedge clock);
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
        check("t5_overflow_cleared", a_ovf, 0);

        // reset in the middle of data bit 3, with an entry already queued
        cfg_expect = 8'h55;
        @(negedge clock);
        send_a(8'h11, 1'b1);
        @(negedge clock);
        check("t6_queued", a_valid, 1);
        fork
            send_a(8'hF8, 1'b1);
            begin
                #(4 * BIT + BIT / 4);
                resetb = 1'b0;
                #20;
                check("t6_reset_outputs", {a_valid, a_data, a_fe, a_pe, a_ovf, a_busy}, 0);
                #30;
                resetb = 1'b1;
            end
        join
        @(negedge clock);
        check("t6_no_partial_frame", a_valid, 0);
        check("t6_idle", a_busy, 0);
        m0 = a_match_n;
        send_a(8'h55, 1'b1);
        @(negedge clock);
        check("t6_data", a_data, 8'h55);
        check("t6_flags", {a_fe, a_pe}, 0);
        check("t6_match_pulses", a_match_n - m0, 1);
        pop_one();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
